matrix_frame_ctrl: RTL and testbench

Double-buffered frame controller for the 5-column x 8-row LED matrix scanner. It holds two 5x8 frame buffers and shares write access to the back buffer between two requesters: the game engine (A) and the score/text overlay (B), using round-robin arbitration. On request it swaps front and back only at a scan-frame boundary, so the scanner never shows a torn frame. The front buffer drives the scanner's five line inputs directly.

---
 rtl/matrix_frame_ctrl_if.sv | 42 ++++
 rtl/matrix_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_matrix_frame_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_frame_ctrl_if.sv
// ============================================================================
// matrix_frame_ctrl_if
// Requester write ports, swap control and status for the LED matrix frame
// controller. The master side is the system (engine, overlay, scanner); the
// slave side is the frame controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface matrix_frame_ctrl_if;
  // Requester A (game engine)
  logic       a_req;
  logic [2:0] a_col;
  logic [7:0] a_data;
  logic       a_gnt;
  // Requester B (score/text overlay)
  logic       b_req;
  logic [2:0] b_col;
  logic [7:0] b_data;
  logic       b_gnt;
  // Swap control, scanner timing and status
  logic       swap_req;
  logic       frame_tick;
  logic       blank;
  logic       swap_busy;
  logic       swap_ack;
  logic       wr_err;

  modport master (
    output a_req, a_col, a_data, b_req, b_col, b_data,
    output swap_req, frame_tick, blank,
    input  a_gnt, b_gnt, swap_busy, swap_ack, wr_err
  );

  modport slave (
    input  a_req, a_col, a_data, b_req, b_col, b_data,
    input  swap_req, frame_tick, blank,
    output a_gnt, b_gnt, swap_busy, swap_ack, wr_err
  );
endinterface

`default_nettype wire

// File: rtl/matrix_frame_ctrl.sv
// ============================================================================
// matrix_frame_ctrl
// Double-buffered 5x8 frame store for the LED matrix scanner. Two requesters
// share write access to the back buffer through a round-robin arbiter; the
// front/back swap is deferred to a scanner frame boundary so no frame tears.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_frame_ctrl #(
  parameter bit CLEAR_ON_SWAP = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  matrix_frame_ctrl_if.slave   bus,
  output logic [7:0]           linha0_o,
  output logic [7:0]           linha1_o,
  output logic [7:0]           linha2_o,
  output logic [7:0]           linha3_o,
  output logic [7:0]           linha4_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SWAP = 2'd2
  } state_e;

  localparam logic [2:0] LAST_COL = 3'd4;

  state_e     state_q;
  logic       front_sel_q;
  logic       last_gnt_b_q;   // 1: B was granted most recently
  logic       swap_busy_q;
  logic       swap_ack_q;
  logic       a_gnt_q;
  logic       b_gnt_q;
  logic       wr_err_q;
  logic [7:0] buf_q   [2][5];
  logic [7:0] linha_q [5];

  logic       swap_edge;
  logic       back_sel;
  logic       a_gnt_d;
  logic       b_gnt_d;
  logic       wr_err_d;
  logic       wr_en_d;
  logic [2:0] wr_col_d;
  logic [7:0] wr_data_d;

  // Round-robin winner selection and write-port mux; no grant on a swap edge
  always_comb begin
    swap_edge = (state_q == ST_SWAP);
    back_sel  = ~front_sel_q;
    a_gnt_d   = ~swap_edge & bus.a_req & (~bus.b_req | last_gnt_b_q);
    b_gnt_d   = ~swap_edge & bus.b_req & ~a_gnt_d;
    wr_col_d  = a_gnt_d ? bus.a_col  : bus.b_col;
    wr_data_d = a_gnt_d ? bus.a_data : bus.b_data;
    wr_err_d  = (a_gnt_d | b_gnt_d) & (wr_col_d > LAST_COL);
    wr_en_d   = (a_gnt_d | b_gnt_d) & (wr_col_d <= LAST_COL);
  end

  // Swap FSM: wait for a frame boundary, then flip buffers for one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      front_sel_q <= 1'b0;
      swap_busy_q <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      swap_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A coincident frame_tick is deliberately not honoured here
          if (bus.swap_req) begin
            state_q     <= ST_PEND;
            swap_busy_q <= 1'b1;
          end
        end
        ST_PEND: begin
          if (bus.frame_tick) begin
            state_q <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          front_sel_q <= ~front_sel_q;
          swap_ack_q  <= 1'b1;
          swap_busy_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          swap_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Grant pulses, column error flag and round-robin history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      wr_err_q     <= 1'b0;
      last_gnt_b_q <= 1'b1;
    end else begin
      a_gnt_q  <= a_gnt_d;
      b_gnt_q  <= b_gnt_d;
      wr_err_q <= wr_err_d;
      if (a_gnt_d | b_gnt_d) begin
        last_gnt_b_q <= b_gnt_d;
      end
    end
  end

  // Frame storage: back-buffer writes, optional clear of the outgoing front
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < 5; c++) begin
          buf_q[b][c] <= 8'h00;
        end
      end
    end else if (swap_edge) begin
      // The current front becomes the back after this edge
      if (CLEAR_ON_SWAP) begin
        for (int c = 0; c < 5; c++) begin
          buf_q[front_sel_q][c] <= 8'h00;
        end
      end
    end else if (wr_en_d) begin
      buf_q[back_sel][wr_col_d] <= wr_data_d;
    end
  end

  // Registered scanner lines from the front buffer, gated by blank
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < 5; c++) begin
        linha_q[c] <= 8'h00;
      end
    end else begin
      for (int c = 0; c < 5; c++) begin
        linha_q[c] <= bus.blank ? 8'h00 : buf_q[front_sel_q][c];
      end
    end
  end

  assign bus.a_gnt     = a_gnt_q;
  assign bus.b_gnt     = b_gnt_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.swap_busy = swap_busy_q;
  assign bus.swap_ack  = swap_ack_q;

  assign linha0_o = linha_q[0];
  assign linha1_o = linha_q[1];
  assign linha2_o = linha_q[2];
  assign linha3_o = linha_q[3];
  assign linha4_o = linha_q[4];

endmodule

`default_nettype wire

// File: tb/tb_matrix_frame_ctrl.sv
// ============================================================================
// tb_matrix_frame_ctrl
// Self-checking bench for matrix_frame_ctrl: directed scenarios plus a
// randomized run against a behavioural frame-store model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matrix_frame_ctrl_if bus ();
  matrix_frame_ctrl_if bus1 ();

  logic [7:0] lin0, lin1, lin2, lin3, lin4;
  logic [7:0] k0, k1, k2, k3, k4;

  matrix_frame_ctrl #(.CLEAR_ON_SWAP(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus.slave),
    .linha0_o(lin0), .linha1_o(lin1), .linha2_o(lin2), .linha3_o(lin3), .linha4_o(lin4)
  );

  matrix_frame_ctrl #(.CLEAR_ON_SWAP(1'b1)) dut_clr (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave),
    .linha0_o(k0), .linha1_o(k1), .linha2_o(k2), .linha3_o(k3), .linha4_o(k4)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model of the CLEAR_ON_SWAP=0 unit --------
  logic [7:0] m_buf [2][5];   // frame contents
  int         m_front;        // index of the buffer being shown
  bit         m_pending;      // swap requested, waiting for a frame tick
  bit         m_swap_now;     // the coming edge performs the swap
  bit         m_b_last;       // B was the most recent winner
  logic       e_agnt, e_bgnt, e_werr, e_busy, e_ack;
  logic [7:0] e_lin [5];

  task automatic model_reset();
    for (int b = 0; b < 2; b++) for (int c = 0; c < 5; c++) m_buf[b][c] = 8'h00;
    m_front = 0; m_pending = 0; m_swap_now = 0; m_b_last = 1;
    e_agnt = 0; e_bgnt = 0; e_werr = 0; e_busy = 0; e_ack = 0;
    for (int c = 0; c < 5; c++) e_lin[c] = 8'h00;
  endtask

  // Predict what the outputs show after the next rising edge
  task automatic model_step();
    bit a_win, b_win;
    int col;
    for (int c = 0; c < 5; c++) e_lin[c] = bus.blank ? 8'h00 : m_buf[m_front][c];
    e_agnt = 0; e_bgnt = 0; e_werr = 0; e_ack = 0;
    if (m_swap_now) begin
      m_front    = 1 - m_front;
      m_swap_now = 0;
      m_pending  = 0;
      e_ack      = 1;
    end else begin
      a_win = bus.a_req && (!bus.b_req || m_b_last);
      b_win = bus.b_req && !a_win;
      if (a_win || b_win) begin
        col = a_win ? int'(bus.a_col) : int'(bus.b_col);
        if (col < 5) m_buf[1 - m_front][col] = a_win ? bus.a_data : bus.b_data;
        else e_werr = 1;
        e_agnt = a_win; e_bgnt = b_win; m_b_last = b_win;
      end
      if (m_pending && bus.frame_tick) m_swap_now = 1;
      else if (!m_pending && bus.swap_req) m_pending = 1;
    end
    e_busy = m_pending;
  endtask

  function automatic logic [44:0] exp_vec();
    return {e_agnt, e_bgnt, e_werr, e_busy, e_ack, e_lin[0], e_lin[1], e_lin[2], e_lin[3], e_lin[4]};
  endfunction

  function automatic logic [44:0] obs_vec();
    return {bus.a_gnt, bus.b_gnt, bus.wr_err, bus.swap_busy, bus.swap_ack, lin0, lin1, lin2, lin3, lin4};
  endfunction

  // One clock: model predicts, DUT clocks, outputs sampled on the falling edge
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.a_req = 0; bus.a_col = 0; bus.a_data = 0;
    bus.b_req = 0; bus.b_col = 0; bus.b_data = 0;
    bus.swap_req = 0; bus.frame_tick = 0; bus.blank = 0;
    bus1.a_req = 0; bus1.a_col = 0; bus1.a_data = 0;
    bus1.b_req = 0; bus1.b_col = 0; bus1.b_data = 0;
    bus1.swap_req = 0; bus1.frame_tick = 0; bus1.blank = 0;
  endtask

  // Full swap on both units; lines show the new front afterwards
  task automatic do_swap();
    bus.swap_req = 1; bus1.swap_req = 1; step();
    bus.swap_req = 0; bus1.swap_req = 0;
    bus.frame_tick = 1; bus1.frame_tick = 1; step();
    bus.frame_tick = 0; bus1.frame_tick = 0;
    step();
    step();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL swap_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  // ---------------- scenarios --------------------------------------------
  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 6; i++) begin
      bus.a_req = 1'($urandom); bus.a_col = 3'($urandom); bus.a_data = 8'($urandom);
      bus.b_req = 1'($urandom); bus.b_col = 3'($urandom); bus.b_data = 8'($urandom);
      bus.swap_req = 1'($urandom); bus.frame_tick = 1'($urandom); bus.blank = 1'($urandom);
      @(posedge clk); @(negedge clk);
      checks++;
      if (obs_vec() !== 45'd0) begin
        errors++; $display("FAIL reset_outputs: got %h expected 0", obs_vec());
      end
    end
    idle_inputs();
    rst_n = 1;
    model_reset();
    bus.a_req = 1; bus.a_col = 3'd2; bus.a_data = 8'hA5;
    step();
    bus.a_req = 0;
    checks++;
    if (bus.a_gnt !== 1'b1) begin
      errors++; $display("FAIL reset_first_gnt: got %b expected 1", bus.a_gnt);
    end
    do_swap();
    checks++;
    if ({lin0, lin1, lin2, lin3, lin4} !== {8'h00, 8'h00, 8'hA5, 8'h00, 8'h00}) begin
      errors++; $display("FAIL reset_a5_line: got %h expected 0000a50000", {lin0, lin1, lin2, lin3, lin4});
    end
  endtask

  task automatic test_fairness();
    logic [7:0] last_a, last_b;
    last_a = 0; last_b = 0;
    bus.b_req = 1; bus.b_col = 3'd4; bus.b_data = 8'($urandom);
    step();
    bus.b_req = 0;
    for (int i = 0; i < 6; i++) begin
      bus.a_req = 1; bus.a_col = 3'd1; bus.a_data = 8'($urandom);
      bus.b_req = 1; bus.b_col = 3'd3; bus.b_data = 8'($urandom);
      step();
      if (i % 2 == 0) last_a = bus.a_data; else last_b = bus.b_data;
      checks++;
      if ({bus.a_gnt, bus.b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL fair_seq[%0d]: got a=%b b=%b expected %s", i, bus.a_gnt, bus.b_gnt, (i % 2 == 0) ? "A" : "B");
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL fair_model[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    bus.a_req = 0; bus.b_req = 0;
    step();
    checks++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b00) begin
      errors++; $display("FAIL fair_release: got %b expected 00", {bus.a_gnt, bus.b_gnt});
    end
    do_swap();
    checks++;
    if ({lin1, lin3} !== {last_a, last_b}) begin
      errors++; $display("FAIL fair_lastdata: got %h expected %h", {lin1, lin3}, {last_a, last_b});
    end
  endtask

  task automatic test_boundary();
    logic [39:0] front_before;
    front_before = {lin0, lin1, lin2, lin3, lin4};
    bus.b_req = 1; bus.b_col = 3'd6; bus.b_data = 8'hFF;
    step();
    bus.b_req = 0;
    checks++;
    if ({bus.b_gnt, bus.wr_err, bus.a_gnt} !== 3'b110) begin
      errors++; $display("FAIL bnd_gnt_err: got %b expected 110", {bus.b_gnt, bus.wr_err, bus.a_gnt});
    end
    step();
    checks++;
    if ({bus.wr_err, lin0, lin1, lin2, lin3, lin4} !== {1'b0, front_before}) begin
      errors++; $display("FAIL bnd_front: got %h expected %h", {bus.wr_err, lin0, lin1, lin2, lin3, lin4}, {1'b0, front_before});
    end
    do_swap();
  endtask

  task automatic test_swap_timing();
    int busy_n, ack_n;
    busy_n = 0; ack_n = 0;
    bus.swap_req = 1; step(); bus.swap_req = 0;
    busy_n += int'(bus.swap_busy); ack_n += int'(bus.swap_ack);
    for (int i = 0; i < 9; i++) begin
      step(); busy_n += int'(bus.swap_busy); ack_n += int'(bus.swap_ack);
    end
    bus.frame_tick = 1; step(); bus.frame_tick = 0;
    busy_n += int'(bus.swap_busy); ack_n += int'(bus.swap_ack);
    for (int i = 0; i < 3; i++) begin
      step(); busy_n += int'(bus.swap_busy); ack_n += int'(bus.swap_ack);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL swap_model[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (busy_n !== 11 || ack_n !== 1) begin
      errors++; $display("FAIL swap_busy_len: got busy=%0d ack=%0d expected busy=11 ack=1", busy_n, ack_n);
    end
    // swap_req coincident with frame_tick: only enters pending
    bus.swap_req = 1; bus.frame_tick = 1; step();
    bus.swap_req = 0; bus.frame_tick = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.swap_busy, bus.swap_ack} !== 2'b10) begin
        errors++; $display("FAIL swap_coinc[%0d]: got %b expected 10", i, {bus.swap_busy, bus.swap_ack});
      end
    end
    bus.frame_tick = 1; step(); bus.frame_tick = 0;
    step();
    checks++;
    if (bus.swap_ack !== 1'b1) begin
      errors++; $display("FAIL swap_coinc_ack: got %b expected 1", bus.swap_ack);
    end
    // request present on the swap edge is held over one cycle
    bus.swap_req = 1; step(); bus.swap_req = 0;
    bus.frame_tick = 1; step(); bus.frame_tick = 0;
    bus.a_req = 1; bus.a_col = 3'd0; bus.a_data = 8'($urandom);
    step();
    checks++;
    if ({bus.a_gnt, bus.swap_ack} !== 2'b01) begin
      errors++; $display("FAIL swap_edge_hold: got %b expected 01", {bus.a_gnt, bus.swap_ack});
    end
    step();
    bus.a_req = 0;
    checks++;
    if (bus.a_gnt !== 1'b1) begin
      errors++; $display("FAIL swap_edge_late_gnt: got %b expected 1", bus.a_gnt);
    end
    step();
  endtask

  task automatic test_clear_on_swap();
    for (int c = 0; c < 5; c++) begin
      bus.a_req = 1; bus.a_col = 3'(c); bus.a_data = 8'h11;
      bus1.a_req = 1; bus1.a_col = 3'(c); bus1.a_data = 8'h11;
      step();
    end
    bus.a_req = 0; bus1.a_req = 0;
    do_swap();
    checks++;
    if ({lin0, lin1, lin2, lin3, lin4, k0, k1, k2, k3, k4} !== {10{8'h11}}) begin
      errors++; $display("FAIL clr_pattern: got %h expected all 11", {lin0, lin1, lin2, lin3, lin4, k0, k1, k2, k3, k4});
    end
    do_swap();
    do_swap();
    checks++;
    if ({lin0, lin1, lin2, lin3, lin4} !== {5{8'h11}}) begin
      errors++; $display("FAIL clr0_return: got %h expected 1111111111", {lin0, lin1, lin2, lin3, lin4});
    end
    checks++;
    if ({k0, k1, k2, k3, k4} !== 40'd0) begin
      errors++; $display("FAIL clr1_zero: got %h expected 0", {k0, k1, k2, k3, k4});
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] val;
    bus.swap_req = 1; step(); bus.swap_req = 0;
    checks++;
    if (bus.swap_busy !== 1'b1) begin
      errors++; $display("FAIL mrst_pend: got %b expected 1", bus.swap_busy);
    end
    rst_n = 0;
    #1;
    checks++;
    if (obs_vec() !== 45'd0) begin
      errors++; $display("FAIL mrst_async: got %h expected 0", obs_vec());
    end
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    bus.frame_tick = 1; step(); bus.frame_tick = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.swap_ack !== 1'b0 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL mrst_noswap[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    val = 8'($urandom_range(1, 255));
    bus.a_req = 1; bus.a_col = 3'd0; bus.a_data = val; step(); bus.a_req = 0;
    do_swap();
    bus.blank = 1; step();
    checks++;
    if ({lin0, lin1, lin2, lin3, lin4} !== 40'd0) begin
      errors++; $display("FAIL blank_on: got %h expected 0", {lin0, lin1, lin2, lin3, lin4});
    end
    bus.blank = 0; step();
    checks++;
    if (lin0 !== val) begin
      errors++; $display("FAIL blank_off: got %h expected %h", lin0, val);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.a_req = 1'($urandom); bus.a_col = 3'($urandom_range(0, 7)); bus.a_data = 8'($urandom);
      bus.b_req = 1'($urandom); bus.b_col = 3'($urandom_range(0, 7)); bus.b_data = 8'($urandom);
      bus.swap_req = ($urandom_range(0, 9) == 0);
      bus.frame_tick = ($urandom_range(0, 3) == 0);
      bus.blank = ($urandom_range(0, 7) == 0);
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_fairness();
    test_boundary();
    test_swap_timing();
    test_clear_on_swap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
